fetch_unit: RTL and testbench

//  Clocked instruction-fetch datapath driven by the asynchronous pipeline controller's fetch request (req1).

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Clocked instruction fetch behind a 4-phase req/ack handshake: synchronise req, read one word, hold it, ack.
// Optional build macro FETCH_TIMEOUT_EN bounds the wait for imem_ready_i to TIMEOUT cycles.
module fetch_unit #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = '0,
   parameter logic [XLEN-1:0]  NOP_INSTR = 32'h13,
   parameter int               TIMEOUT   = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_i,
   output logic            ack_o,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] branch_target_i,
   output logic [XLEN-1:0] imem_addr_o,
   output logic            imem_rd_o,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            imem_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [6:0]      opcode_o,
   output logic [XLEN-1:0] pc_o,
   output logic            fetch_err_o
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_RELEASE} state_e;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fetch_unit: TIMEOUT must be at least 1");
   end

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic            req_s;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] next_pc_q, next_pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            err_q, err_d;
   logic            ack_q, ack_d;
   logic [XLEN-1:0] fetch_addr;

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   // req_i is asynchronous to clk; only the second flop's output is ever used.
   assign req_s      = sync_q[1];
   assign fetch_addr = branch_taken_i ? branch_target_i : next_pc_q;

   always_comb begin
      // NOTE: every next-state value gets a default first, so no path leaves one unassigned (no latch).
      state_d   = state_q;
      addr_d    = addr_q;
      next_pc_d = next_pc_q;
      instr_d   = instr_q;
      pc_d      = pc_q;
      err_d     = err_q;
      ack_d     = ack_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_s) begin
               addr_d = fetch_addr;
               if (fetch_addr[1:0] != 2'b00) begin
                  // Misaligned: never touch memory, report a NOP with the error flag.
                  instr_d   = NOP_INSTR;
                  pc_d      = fetch_addr;
                  err_d     = 1'b1;
                  next_pc_d = fetch_addr + XLEN'(4);
                  ack_d     = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  state_d = S_ISSUE;
`ifdef FETCH_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         S_ISSUE, S_WAIT: begin
            if (imem_ready_i) begin
               instr_d   = imem_rdata_i;
               pc_d      = addr_q;
               err_d     = 1'b0;
               next_pc_d = addr_q + XLEN'(4);
               ack_d     = 1'b1;
               state_d   = S_DONE;
`ifdef FETCH_TIMEOUT_EN
            end else if (state_q == S_WAIT && cnt_q == CW'(TIMEOUT - 1)) begin
               instr_d   = NOP_INSTR;
               pc_d      = addr_q;
               err_d     = 1'b1;
               next_pc_d = addr_q + XLEN'(4);
               ack_d     = 1'b1;
               state_d   = S_DONE;
            end else begin
               if (state_q == S_WAIT) cnt_d = cnt_q + CW'(1);
               state_d = S_WAIT;
`else
            end else begin
               state_d = S_WAIT;
`endif
            end
         end
         S_DONE: begin
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments and reset asynchronously on reset=1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         sync_q    <= '0;
         addr_q    <= '0;
         next_pc_q <= RESET_PC;
         instr_q   <= NOP_INSTR;
         pc_q      <= '0;
         err_q     <= 1'b0;
         ack_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[0], req_i};
         addr_q    <= addr_d;
         next_pc_q <= next_pc_d;
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         err_q     <= err_d;
         ack_q     <= ack_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // Strobe decodes straight from state so a reset pulse removes it without waiting for a clock.
   assign imem_rd_o   = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign imem_addr_o = addr_q;
   assign ack_o       = ack_q;
   assign instr_o     = instr_q;
   assign opcode_o    = instr_q[6:0];
   assign pc_o        = pc_q;
   assign fetch_err_o = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed handshakes plus randomized fetches against a PC/memory model.
module tb_fetch_unit;

   localparam logic [31:0] NOP     = 32'h13;
   localparam int          TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_i = 1'b0;
   logic        ack_o;
   logic        branch_taken_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic [31:0] imem_addr_o;
   logic        imem_rd_o;
   logic [31:0] imem_rdata_i;
   logic        imem_ready_i;
   logic [31:0] instr_o;
   logic [6:0]  opcode_o;
   logic [31:0] pc_o;
   logic        fetch_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Memory model: either a fixed word or an address hash; ready after wait_cfg strobe cycles.
   logic        fixed_en   = 1'b1;
   logic [31:0] fixed_data = 32'h0050_0093;
   logic [31:0] key        = '0;
   int          wait_cfg   = 0;
   int          rd_cnt     = 0;
   logic [31:0] model_pc   = '0;

   fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .req_i           (req_i),
      .ack_o           (ack_o),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .imem_addr_o     (imem_addr_o),
      .imem_rd_o       (imem_rd_o),
      .imem_rdata_i    (imem_rdata_i),
      .imem_ready_i    (imem_ready_i),
      .instr_o         (instr_o),
      .opcode_o        (opcode_o),
      .pc_o            (pc_o),
      .fetch_err_o     (fetch_err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_cnt <= imem_rd_o ? rd_cnt + 1 : 0;

   always_comb begin
      imem_rdata_i = fixed_en ? fixed_data : ((imem_addr_o * 32'h9E37_79B1) ^ key);
      imem_ready_i = imem_rd_o && (rd_cnt >= wait_cfg);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return fixed_en ? fixed_data : ((a * 32'h9E37_79B1) ^ key);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      req_i = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ack", 32'(ack_o), 0);
      check("rst_rd", 32'(imem_rd_o), 0);
      check("rst_addr", imem_addr_o, 0);
      check("rst_instr", instr_o, NOP);
      check("rst_opcode", 32'(opcode_o), 32'h13);
      check("rst_pc", pc_o, 0);
      check("rst_err", 32'(fetch_err_o), 0);
      reset    = 1'b0;
      model_pc = '0;
   endtask

   // One complete 4-phase fetch, with every expectation derived from the model PC and memory.
   task automatic do_fetch(input logic br, input logic [31:0] tgt, input int waits);
      logic [31:0] a, exp_instr;
      logic        mis, tmo, addr_ok;
      int          edges, rdc, exp_rd, exp_edges;
      a   = br ? tgt : model_pc;
      mis = (a[1:0] != 2'b00);
`ifdef FETCH_TIMEOUT_EN
      tmo = !mis && (waits > TIMEOUT);
`else
      tmo = 1'b0;
`endif
      exp_instr = (mis || tmo) ? NOP : mem_word(a);
      exp_rd    = mis ? 0 : (tmo ? TIMEOUT + 1 : waits + 1);
      exp_edges = mis ? 3 : (tmo ? 4 + TIMEOUT : 4 + waits);
      model_pc  = a + 32'd4;

      @(negedge clk);
      branch_taken_i  = br;
      branch_target_i = tgt;
      wait_cfg        = waits;
      req_i           = 1'b1;
      edges = 0; rdc = 0; addr_ok = 1'b1;
      while (ack_o !== 1'b1 && edges < 100) begin
         @(posedge clk); #1;
         edges++;
         if (imem_rd_o === 1'b1) begin
            rdc++;
            if (imem_addr_o !== a) addr_ok = 1'b0;
         end
      end
      check("ack_rise_edge", 32'(edges), 32'(exp_edges));
      check("rd_cycles", 32'(rdc), 32'(exp_rd));
      check("addr_held", 32'(addr_ok), 1);
      check("instr", instr_o, exp_instr);
      check("opcode", 32'(opcode_o), 32'(exp_instr[6:0]));
      check("pc", pc_o, a);
      check("err", 32'(fetch_err_o), 32'(mis || tmo));

      // Branch inputs are ignored outside IDLE: scramble them while ack is held.
      branch_taken_i  = 1'($urandom);
      branch_target_i = $urandom;
      repeat (3) @(posedge clk);
      #1;
      check("ack_hold", 32'(ack_o), 1);
      check("instr_hold", instr_o, exp_instr);
      check("pc_hold", pc_o, a);

      @(negedge clk);
      req_i = 1'b0;
      edges = 0;
      while (ack_o !== 1'b0 && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      check("ack_fall_edge", 32'(edges), 3);
      repeat (2) @(posedge clk);
      #1;
      check("ack_stays_low", 32'(ack_o), 0);
   endtask

   initial begin
      logic [31:0] tgt;
      logic        ack_seen;
      key = $urandom;

      // Reset values, then the basic single fetch.
      do_reset();
      do_fetch(1'b0, 32'h0, 0);

      // Four back-to-back handshakes from a fresh reset: pc 0,4,8,12.
      do_reset();
      fixed_data = 32'h0000_0033;
      for (int i = 0; i < 4; i++) do_fetch(1'b0, 32'h0, 0);

      // Branch redirect with memory wait states.
      fixed_en = 1'b0;
      do_fetch(1'b1, 32'h100, 3);

      // Misaligned target, then the sequential follow-on stays misaligned.
      do_fetch(1'b1, 32'h102, 0);
      do_fetch(1'b0, 32'h0, 0);

      // Next-PC wrap at the top of the address space.
      do_fetch(1'b1, 32'hFFFF_FFFC, 1);
      do_fetch(1'b0, 32'h0, 0);

      // Randomized mix of sequential, branched, misaligned fetches and wait states.
      for (int i = 0; i < 24; i++) begin
         tgt = $urandom;
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         do_fetch(1'($urandom_range(0, 1)), tgt, $urandom_range(0, 4));
      end

`ifdef FETCH_TIMEOUT_EN
      do_fetch(1'b0, 32'h0, 5000);
`endif

      // Memory never ready: fetch stalls without ack, then a reset pulse mid-wait aborts it.
      @(negedge clk);
      branch_taken_i = 1'b0;
      wait_cfg       = 32'h7FFF_FFFF;
      req_i          = 1'b1;
      ack_seen       = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (ack_o === 1'b1) ack_seen = 1'b1;
      end
`ifndef FETCH_TIMEOUT_EN
      check("no_ack_1000", 32'(ack_seen), 0);
      check("still_waiting_rd", 32'(imem_rd_o), 1);
`endif
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("abort_ack", 32'(ack_o), 0);
      check("abort_rd", 32'(imem_rd_o), 0);
      wait_cfg = 0;
      fixed_en = 1'b0;
      do_reset();
      do_fetch(1'b0, 32'h0, 2);
      check("post_reset_next_pc", pc_o, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
